// File: rtl/nios2_jtag_dbg_pkg.sv
// Shared definitions for the Nios II JTAG debug command bridge.
// IR codes and the default-width command entry used by OCI consumers.
package nios2_jtag_dbg_pkg;

  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  localparam int CMD_IR_W = 2;
  localparam int CMD_SR_W = 38;

  typedef struct packed {
    logic [CMD_IR_W-1:0] ir;
    logic [CMD_SR_W-1:0] data;
  } cmd_entry_t;

endpackage

// File: rtl/nios2_jtag_dbg_sync.sv
// Multi-flop bit synchroniser for TCK-domain update strobes.
// Emits a single-cycle pulse on each synchronised rising edge.
module nios2_jtag_dbg_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              dly;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
      dly   <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      dly   <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~dly;

endmodule

// File: rtl/nios2_jtag_debug_cmd_bridge.sv
// Sysclk-side bridge from the virtual-JTAG PHY to the OCI core logic.
// Queues update-DR captures and issues per-IR action pulses on accept.
module nios2_jtag_debug_cmd_bridge
  import nios2_jtag_dbg_pkg::*;
#(
  parameter  int IR_W        = 2,
  parameter  int SR_W        = 38,
  parameter  int ACT_BIT     = 35,
  parameter  int DEPTH       = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int ACT_W       = 2**IR_W,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int LVL_W       = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             vs_uir,
  input  logic             vs_udr,
  input  logic [IR_W-1:0]  ir_in,
  input  logic [SR_W-1:0]  sr,
  input  logic             cmd_ready,
  input  logic             ovf_clr,
  output logic             cmd_valid,
  output logic [IR_W-1:0]  cmd_ir,
  output logic [SR_W-1:0]  cmd_data,
  output logic [SR_W-1:0]  jdo,
  output logic [ACT_W-1:0] take_action,
  output logic [ACT_W-1:0] take_no_action,
  output logic [LVL_W-1:0] level,
  output logic             overflow
);

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head_e;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [IR_W-1:0]    ir_lat;
  logic [IR_W-1:0]    ir_cap;
  logic [ACT_W-1:0]   ir_hot;
  logic               uir_rise;
  logic               udr_rise;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;

  nios2_jtag_dbg_sync #(.STAGES(SYNC_STAGES)) u_uir_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (vs_uir),
    .rise    (uir_rise)
  );

  nios2_jtag_dbg_sync #(.STAGES(SYNC_STAGES)) u_udr_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (vs_udr),
    .rise    (udr_rise)
  );

  // A same-cycle IR update must tag the DR capture it coincides with.
  assign ir_cap = uir_rise ? ir_in : ir_lat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_lat <= '0;
    end else if (uir_rise) begin
      ir_lat <= ir_in;
    end
  end

  assign cmd_valid = (level != '0);
  assign full      = (level == LVL_W'(DEPTH));
  assign pop       = cmd_valid & cmd_ready;
  assign push      = udr_rise & (~full | pop);
  assign drop      = udr_rise & full & ~pop;

  assign head_e   = mem[head];
  assign cmd_ir   = head_e.ir;
  assign cmd_data = head_e.data;
  assign ir_hot   = ACT_W'(1) << head_e.ir;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{ir: ir_cap, data: sr};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      unique case (1'b1)
        push & ~pop: level <= level + LVL_W'(1);
        pop & ~push: level <= level - LVL_W'(1);
        default:     level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      if (pop) begin
        jdo <= head_e.data;
        if (head_e.data[ACT_BIT]) take_action    <= ir_hot;
        else                      take_no_action <= ir_hot;
      end
    end
  end

endmodule

// File: tb/tb_nios2_jtag_debug_cmd_bridge.sv
// Self-checking bench: table vectors, directed corner cases, and
// randomized traffic against a queue-based reference model.
module tb_nios2_jtag_debug_cmd_bridge;
  import nios2_jtag_dbg_pkg::*;

  localparam int IR_W    = 2;
  localparam int SR_W    = 38;
  localparam int ACT_BIT = 35;
  localparam int DEPTH   = 4;
  localparam int SYNC    = 2;
  localparam int ACT_W   = 4;
  localparam int LVL_W   = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             vs_uir = 1'b0;
  logic             vs_udr = 1'b0;
  logic [IR_W-1:0]  ir_in = '0;
  logic [SR_W-1:0]  sr = '0;
  logic             cmd_ready = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             cmd_valid;
  logic [IR_W-1:0]  cmd_ir;
  logic [SR_W-1:0]  cmd_data;
  logic [SR_W-1:0]  jdo;
  logic [ACT_W-1:0] take_action;
  logic [ACT_W-1:0] take_no_action;
  logic [LVL_W-1:0] level;
  logic             overflow;

  always #5 clk = ~clk;

  nios2_jtag_debug_cmd_bridge #(
    .IR_W(IR_W), .SR_W(SR_W), .ACT_BIT(ACT_BIT),
    .DEPTH(DEPTH), .SYNC_STAGES(SYNC)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vs_uir         (vs_uir),
    .vs_udr         (vs_udr),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_ready      (cmd_ready),
    .ovf_clr        (ovf_clr),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .cmd_data       (cmd_data),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .level          (level),
    .overflow       (overflow)
  );

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] data;
  } ent_t;

  typedef struct {
    logic [IR_W-1:0]  ir;
    logic             act;
    logic [ACT_W-1:0] exp_act;
    logic [ACT_W-1:0] exp_noact;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t             mq[$];
  bit               hu[$];
  bit               hi[$];
  logic             m_ovf;
  logic [SR_W-1:0]  m_jdo;
  logic [ACT_W-1:0] m_act;
  logic [ACT_W-1:0] m_noact;
  logic [IR_W-1:0]  m_ir_lat;

  task automatic check(input string name, input logic [63:0] a,
                       input logic [63:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    hu.delete();
    hi.delete();
    for (int i = 0; i <= SYNC; i++) begin
      hu.push_back(1'b0);
      hi.push_back(1'b0);
    end
    m_ovf    = 1'b0;
    m_jdo    = '0;
    m_act    = '0;
    m_noact  = '0;
    m_ir_lat = '0;
  endtask

  // Rise is seen SYNC edges after sampling; acted on at the following edge.
  task automatic model_step();
    bit ur, dr, pop, drop;
    ent_t e;
    logic [IR_W-1:0] cap;
    if (!reset_n) begin
      model_reset();
      return;
    end
    ur = hi[SYNC-1] & ~hi[SYNC];
    dr = hu[SYNC-1] & ~hu[SYNC];
    hi.push_front(vs_uir);
    void'(hi.pop_back());
    hu.push_front(vs_udr);
    void'(hu.pop_back());
    cap = ur ? ir_in : m_ir_lat;
    if (ur) m_ir_lat = ir_in;
    m_act   = '0;
    m_noact = '0;
    pop = (mq.size() > 0) && cmd_ready;
    if (pop) begin
      e = mq.pop_front();
      m_jdo = e.data;
      if (e.data[ACT_BIT]) m_act[e.ir] = 1'b1;
      else                 m_noact[e.ir] = 1'b1;
    end
    drop = dr && (mq.size() == DEPTH);
    if (dr && !drop) mq.push_back('{ir: cap, data: sr});
    if (drop)         m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endtask

  task automatic compare_all();
    check("level", 64'(level), 64'(mq.size()));
    check("cmd_valid", 64'(cmd_valid), 64'(mq.size() != 0));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("jdo", 64'(jdo), 64'(m_jdo));
    check("take_action", 64'(take_action), 64'(m_act));
    check("take_no_action", 64'(take_no_action), 64'(m_noact));
    if (mq.size() > 0) begin
      check("cmd_ir", 64'(cmd_ir), 64'(mq[0].ir));
      check("cmd_data", 64'(cmd_data), 64'(mq[0].data));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_cmd(input logic [IR_W-1:0] ir,
                          input logic [SR_W-1:0] d, input bit both);
    if (!both) begin
      ir_in  = ir;
      vs_uir = 1'b1;
      ticks(2);
      vs_uir = 1'b0;
      ticks(2);
      sr     = d;
      vs_udr = 1'b1;
      ticks(2);
      vs_udr = 1'b0;
      ticks(2);
    end else begin
      ir_in  = ir;
      sr     = d;
      vs_uir = 1'b1;
      vs_udr = 1'b1;
      ticks(2);
      vs_uir = 1'b0;
      vs_udr = 1'b0;
      ticks(2);
    end
  endtask

  function automatic logic [SR_W-1:0] rnd_sr();
    return SR_W'({$urandom(), $urandom()});
  endfunction

  vec_t            vecs[6];
  logic [SR_W-1:0] dv[5];
  logic [SR_W-1:0] d;
  int              cnt;
  int              thr;

  initial begin
    vecs[0] = '{IR_BREAK,     1'b1, 4'b0100, 4'b0000};
    vecs[1] = '{IR_OCIMEM,    1'b0, 4'b0000, 4'b0001};
    vecs[2] = '{IR_TRACEMEM,  1'b1, 4'b0010, 4'b0000};
    vecs[3] = '{IR_TRACECTRL, 1'b0, 4'b0000, 4'b1000};
    vecs[4] = '{IR_TRACECTRL, 1'b1, 4'b1000, 4'b0000};
    vecs[5] = '{IR_BREAK,     1'b0, 4'b0000, 4'b0100};

    model_reset();
    reset_n = 1'b0;
    ticks(3);
    reset_n = 1'b1;
    tick();
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_jdo", 64'(jdo), 64'd0);

    foreach (vecs[i]) begin
      d = rnd_sr();
      d[ACT_BIT] = vecs[i].act;
      cmd_ready = 1'b0;
      send_cmd(vecs[i].ir, d, 1'b0);
      cmd_ready = 1'b1;
      tick();
      check("vec_act", 64'(take_action), 64'(vecs[i].exp_act));
      check("vec_noact", 64'(take_no_action), 64'(vecs[i].exp_noact));
      check("vec_jdo", 64'(jdo), 64'(d));
      cmd_ready = 1'b0;
      tick();
      check("vec_pulse_end", 64'(take_action | take_no_action), 64'd0);
    end

    sr     = rnd_sr();
    vs_udr = 1'b1;
    cnt    = 0;
    do begin
      tick();
      cnt++;
    end while (!cmd_valid && cnt < 10);
    check("latency", 64'(cnt), 64'(SYNC + 1));
    vs_udr = 1'b0;
    cmd_ready = 1'b1;
    ticks(2);
    cmd_ready = 1'b0;

    foreach (dv[i]) dv[i] = rnd_sr();
    for (int i = 0; i < 5; i++) send_cmd(IR_W'(i % 4), dv[i], 1'b0);
    check("ovf_level", 64'(level), 64'd4);
    check("ovf_flag", 64'(overflow), 64'd1);
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_order", 64'(jdo), 64'(dv[i]));
    end
    cmd_ready = 1'b0;
    tick();
    check("drain_empty", 64'(cmd_valid), 64'd0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 64'(overflow), 64'd0);

    foreach (dv[i]) dv[i] = rnd_sr();
    for (int i = 0; i < 4; i++) send_cmd(IR_W'(i), dv[i], 1'b0);
    sr     = dv[4];
    vs_udr = 1'b1;
    ticks(2);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    vs_udr = 1'b0;
    check("pp_level", 64'(level), 64'd4);
    check("pp_ovf", 64'(overflow), 64'd0);
    check("pp_jdo", 64'(jdo), 64'(dv[0]));
    tick();
    cmd_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      check("pp_order", 64'(jdo), 64'(dv[i]));
    end
    cmd_ready = 1'b0;
    tick();

    send_cmd(IR_TRACEMEM, rnd_sr(), 1'b0);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    send_cmd(IR_TRACECTRL, rnd_sr(), 1'b1);
    check("coincident_ir", 64'(cmd_ir), 64'(IR_TRACECTRL));
    cmd_ready = 1'b1;
    ticks(2);
    cmd_ready = 1'b0;

    for (int i = 0; i < 3; i++) send_cmd(IR_W'(i), rnd_sr(), 1'b0);
    check("mid_level", 64'(level), 64'd3);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("mid_valid", 64'(cmd_valid), 64'd0);
    check("mid_level0", 64'(level), 64'd0);
    check("mid_jdo", 64'(jdo), 64'd0);
    tick();
    reset_n = 1'b1;
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_nopulse", 64'(take_action | take_no_action), 64'd0);
    end
    cmd_ready = 1'b0;

    thr = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0) thr = 15 + $urandom_range(80);
      if ($urandom_range(3) == 0) vs_uir = ~vs_uir;
      if ($urandom_range(2) == 0) vs_udr = ~vs_udr;
      ir_in     = IR_W'($urandom_range(3));
      sr        = rnd_sr();
      cmd_ready = ($urandom_range(99) < thr);
      ovf_clr   = ($urandom_range(15) == 0);
      if ($urandom_range(999) == 0) begin
        reset_n = 1'b0;
        model_reset();
        tick();
        reset_n = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
